// File: rtl/uart_write_arbiter.sv
// Transmit-side write-lock arbiter and byte FIFO between the two thread write
// ports and the UART serializer. Round-robin lock, DEPTH-entry FIFO, valid/ready out.
module uart_write_arbiter #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    write_lock_req,
  output logic [1:0]    write_lock_res,
  input  logic [15:0]   data_in,
  input  logic [1:0]    data_in_valid,
  output logic          write_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  // state | meaning
  // IDLE  | no holder; arbitrate on the next edge
  // HOLD0 | requester 0 owns the write lock
  // HOLD1 | requester 1 owns the write lock
  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

  state_t        state, state_next;
  logic          last, last_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          holder_strobe;
  logic [7:0]    holder_byte;
  logic          push, pop;

  always_comb begin
    state_next     = state;
    last_next      = last;
    write_lock_res = 2'b00;
    holder_strobe  = 1'b0;
    holder_byte    = data_in[7:0];
    case (state)
      IDLE: begin
        case (write_lock_req)
          2'b01:   state_next = HOLD0;
          2'b10:   state_next = HOLD1;
          2'b11:   state_next = last ? HOLD0 : HOLD1;
          default: state_next = IDLE;
        endcase
      end
      HOLD0: begin
        write_lock_res = 2'b01;
        holder_strobe  = data_in_valid[0];
        if (!write_lock_req[0]) begin
          state_next = IDLE;
          last_next  = 1'b0;
        end
      end
      HOLD1: begin
        write_lock_res = 2'b10;
        holder_strobe  = data_in_valid[1];
        holder_byte    = data_in[15:8];
        if (!write_lock_req[1]) begin
          state_next = IDLE;
          last_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign write_ready = !reset && (fifo_count != CW'(DEPTH));
  assign tx_valid    = (fifo_count != '0);
  assign tx_data     = tx_valid ? mem[rd_ptr] : 8'h00;
  assign push        = holder_strobe && write_ready;
  assign pop         = tx_valid && tx_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      last       <= last_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      // A full FIFO drops the holder's byte even if a pop frees a slot this cycle.
      if (holder_strobe && !write_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= holder_byte;
  end

endmodule

// File: tb/tb_uart_write_arbiter.sv
// Randomized and directed bench for uart_write_arbiter against a queue-based
// model of the lock holder, FIFO contents and overflow flag.
module tb_uart_write_arbiter;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic [1:0]    req   = 2'b00;
  logic [1:0]    res;
  logic [15:0]   din   = 16'h0;
  logic [1:0]    dv    = 2'b00;
  logic          wready;
  logic [7:0]    txd;
  logic          txv;
  logic          txr   = 1'b0;
  logic [CW-1:0] cnt;
  logic          ovf;

  int n_checks = 0;
  int n_pass   = 0;

  int         m_holder = -1;
  bit         m_last   = 1'b1;
  bit         m_ovf    = 1'b0;
  logic [7:0] q[$];

  uart_write_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clock(clock), .reset(rst), .write_lock_req(req), .write_lock_res(res),
    .data_in(din), .data_in_valid(dv), .write_ready(wready), .tx_data(txd),
    .tx_valid(txv), .tx_ready(txr), .fifo_count(cnt), .overflow(ovf)
  );

  always #5 clock = ~clock;

  // Model advance at a rising edge, using the inputs held during that cycle.
  function automatic void model_step();
    bit full;
    if (rst) begin
      m_holder = -1; m_last = 1'b1; m_ovf = 1'b0; q.delete();
      return;
    end
    full = (q.size() == DEPTH);
    if (q.size() != 0 && txr) void'(q.pop_front());
    if (m_holder >= 0 && dv[m_holder]) begin
      if (full) m_ovf = 1'b1;
      else q.push_back(m_holder == 0 ? din[7:0] : din[15:8]);
    end
    if (m_holder >= 0) begin
      if (!req[m_holder]) begin m_last = (m_holder == 1); m_holder = -1; end
    end else if (req == 2'b01) m_holder = 0;
    else if (req == 2'b10) m_holder = 1;
    else if (req == 2'b11) m_holder = m_last ? 0 : 1;
  endfunction

  function automatic logic [17:0] exp_vec();
    logic [1:0] r;
    r = (m_holder < 0) ? 2'b00 : (m_holder == 0 ? 2'b01 : 2'b10);
    return {r, (!rst && q.size() != DEPTH), (q.size() != 0),
            (q.size() != 0 ? q[0] : 8'h00), CW'(q.size()), m_ovf};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {res, wready, txv, txd, cnt, ovf};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; dv = 2'b00; txr = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; dv = 2'b11; din = 16'hBEEF; txr = 1'b1;
    tick(); tick();
    n_checks++;
    if (obs_vec() !== 18'h0) $display("FAIL reset_values: got %h want %h", obs_vec(), 18'h0);
    else n_pass++;
    rst = 1'b0; req = 2'b00; dv = 2'b00; txr = 1'b0;
    #1;
    n_checks++;
    if (wready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", wready);
    else n_pass++;
  endtask

  task automatic test_single_grant();
    do_reset();
    txr = 1'b1; req = 2'b01;
    tick();
    n_checks++;
    if (res !== 2'b01 || obs_vec() !== exp_vec()) $display("FAIL grant0: res %b want 01 vec %h model %h", res, obs_vec(), exp_vec());
    else n_pass++;
    dv = 2'b01; din = 16'h00A5;
    tick();
    din = 16'h003C;
    n_checks++;
    if (txd !== 8'hA5 || cnt !== CW'(1)) $display("FAIL first_byte: data %h cnt %0d want a5 1", txd, cnt);
    else n_pass++;
    tick();
    dv = 2'b00;
    n_checks++;
    if (txd !== 8'h3C || cnt !== CW'(1)) $display("FAIL second_byte: data %h cnt %0d want 3c 1", txd, cnt);
    else n_pass++;
    tick();
    n_checks++;
    if (txv !== 1'b0 || cnt !== CW'(0) || obs_vec() !== exp_vec()) $display("FAIL drained: valid %b cnt %0d want 0 0", txv, cnt);
    else n_pass++;
    req = 2'b00;
    tick();
  endtask

  task automatic test_rr_tie();
    do_reset();
    req = 2'b11;
    tick();
    n_checks++;
    if (res !== 2'b01) $display("FAIL tie_first: got %b want 01", res);
    else n_pass++;
    req = 2'b10;
    tick();
    n_checks++;
    if (res !== 2'b00) $display("FAIL idle_gap: got %b want 00", res);
    else n_pass++;
    tick();
    n_checks++;
    if (res !== 2'b10) $display("FAIL grant1: got %b want 10", res);
    else n_pass++;
    req = 2'b00;
    tick();
    req = 2'b11;
    tick();
    n_checks++;
    if (res !== 2'b01 || obs_vec() !== exp_vec()) $display("FAIL tie_second: got %b want 01", res);
    else n_pass++;
    req = 2'b00;
    tick();
  endtask

  task automatic test_full_overflow();
    do_reset();
    req = 2'b01;
    tick();
    dv = 2'b01;
    for (int i = 0; i <= DEPTH; i++) begin
      din = 16'(i);
      tick();
    end
    dv = 2'b00;
    n_checks++;
    if (cnt !== CW'(DEPTH) || wready !== 1'b0 || ovf !== 1'b1)
      $display("FAIL full: cnt %0d ready %b ovf %b want 16 0 1", cnt, wready, ovf);
    else n_pass++;
    txr = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (txv !== 1'b1 || txd !== 8'(i)) $display("FAIL drain_order: valid %b data %h want 1 %h", txv, txd, 8'(i));
      else n_pass++;
      tick();
    end
    n_checks++;
    if (txv !== 1'b0 || cnt !== CW'(0) || ovf !== 1'b1 || obs_vec() !== exp_vec())
      $display("FAIL dropped_absent: valid %b cnt %0d ovf %b want 0 0 1", txv, cnt, ovf);
    else n_pass++;
    req = 2'b00; txr = 1'b0;
    tick();
  endtask

  task automatic test_non_holder();
    do_reset();
    req = 2'b01;
    tick();
    dv = 2'b01; din = 16'h00A5;
    tick();
    dv = 2'b10; din = 16'hFF00;
    tick();
    n_checks++;
    if (cnt !== CW'(1) || ovf !== 1'b0 || txd !== 8'hA5) $display("FAIL non_holder: cnt %0d ovf %b data %h want 1 0 a5", cnt, ovf, txd);
    else n_pass++;
    dv = 2'b00; req = 2'b00;
    tick();
    dv = 2'b01; din = 16'h0077;
    tick();
    n_checks++;
    if (cnt !== CW'(1) || ovf !== 1'b0 || obs_vec() !== exp_vec()) $display("FAIL idle_strobe: cnt %0d ovf %b want 1 0", cnt, ovf);
    else n_pass++;
    dv = 2'b00;
  endtask

  task automatic test_wrap();
    logic [7:0] sent[$];
    logic [7:0] got[$];
    int cyc;
    do_reset();
    req = 2'b10;
    tick();
    cyc = 0;
    while ((sent.size() < 40 || got.size() < sent.size()) && cyc < 400) begin
      txr = cyc[0];
      din = 16'($urandom);
      dv  = (sent.size() < 40 && q.size() < DEPTH - 1 && $urandom_range(0, 3) != 0) ? 2'b10 : 2'b00;
      if (dv[1]) sent.push_back(din[15:8]);
      if (txv && txr) got.push_back(txd);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL wrap_cycle: got %h want %h", obs_vec(), exp_vec());
      else n_pass++;
      cyc++;
    end
    dv = 2'b00; req = 2'b00; txr = 1'b0;
    n_checks++;
    if (cyc >= 400 || got.size() != 40) $display("FAIL wrap_count: got %0d bytes want 40", got.size());
    else n_pass++;
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      n_checks++;
      if (got[i] !== sent[i]) $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], sent[i]);
      else n_pass++;
    end
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL wrap_no_drop: ovf %b want 0", ovf);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b10;
    tick();
    dv = 2'b10;
    for (int i = 0; i < 5; i++) begin
      din = {8'(8'h40 + i), 8'h00};
      tick();
    end
    dv = 2'b00;
    n_checks++;
    if (cnt !== CW'(5) || res !== 2'b10) $display("FAIL pre_reset: cnt %0d res %b want 5 10", cnt, res);
    else n_pass++;
    rst = 1'b1; req = 2'b00;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== {2'b00, 1'b1, 1'b0, 8'h00, CW'(0), 1'b0})
      $display("FAIL post_reset: got %h want %h", obs_vec(), {2'b00, 1'b1, 1'b0, 8'h00, CW'(0), 1'b0});
    else n_pass++;
    req = 2'b11;
    tick();
    n_checks++;
    if (res !== 2'b01) $display("FAIL post_reset_tie: got %b want 01", res);
    else n_pass++;
    req = 2'b00;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 5) == 0) req = 2'($urandom);
      dv  = 2'($urandom);
      din = 16'($urandom);
      txr = ($urandom_range(0, 2) != 0);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL random_cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
    rst = 1'b0; req = 2'b00; dv = 2'b00; txr = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_rr_tie();
    test_full_overflow();
    test_non_holder();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
